// File: rtl/ddfs_note_seq.sv
// Note sequencer feeding a DDFS core: queues {voice, dur, fccw}
// entries and replays them as timed track/fccw register writes.
module ddfs_note_seq #(
  parameter int PW       = 30,
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ddfs_cs,
  output logic        ddfs_write,
  output logic [4:0]  ddfs_addr,
  output logic [31:0] ddfs_wr_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    WR_TRK,
    WR_FCCW,
    PLAY,
    MUTE_TRK,
    MUTE_FCCW
  } state_t;

  state_t state, next;

  logic [1:0]    voice_mem [DEPTH];
  logic [15:0]   dur_mem   [DEPTH];
  logic [PW-1:0] fccw_mem  [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] stage_fccw;
  logic          enable, overflow, flush_pend;
  logic [1:0]    cur_voice;
  logic [PW-1:0] cur_fccw;
  logic [15:0]   cur_dur, remaining;
  logic [TW-1:0] pre;

  logic sel, wr_stage, push_req, ctrl_wr;
  logic flush, clr_ovf, full, empty;
  logic wrap, play_done, can_pop, pop;
  logic do_push, ovf_set;
  logic unused;

  assign unused = ^{read, addr[4:2], wr_data};

  assign sel      = cs & write;
  assign wr_stage = sel & (addr[1:0] == 2'd0);
  assign push_req = sel & (addr[1:0] == 2'd1);
  assign ctrl_wr  = sel & (addr[1:0] == 2'd2);
  assign flush    = ctrl_wr & wr_data[1];
  assign clr_ovf  = ctrl_wr & wr_data[2];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // a full FIFO rejects pushes even when a pop frees a slot
  assign do_push = push_req & ~flush & ~full;
  assign ovf_set = push_req & ~flush & full;

  assign wrap      = (pre == TW'(TICK_DIV - 1));
  assign play_done = (remaining == 16'd0) ||
                     (remaining == 16'd1 && wrap);
  assign can_pop   = enable & ~empty & ~flush;

  always_comb begin
    next         = state;
    pop          = 1'b0;
    ddfs_cs      = 1'b0;
    ddfs_write   = 1'b0;
    ddfs_addr    = 5'd0;
    ddfs_wr_data = 32'd0;
    unique case (state)
      IDLE: begin
        if (can_pop) begin
          pop  = 1'b1;
          next = WR_TRK;
        end
      end
      WR_TRK: begin
        ddfs_cs      = 1'b1;
        ddfs_write   = 1'b1;
        ddfs_addr    = 5'd5;
        ddfs_wr_data = 32'(cur_voice);
        next         = WR_FCCW;
      end
      WR_FCCW: begin
        ddfs_cs      = 1'b1;
        ddfs_write   = 1'b1;
        ddfs_addr    = 5'd0;
        ddfs_wr_data = 32'(cur_fccw);
        next = (flush | flush_pend) ? MUTE_TRK : PLAY;
      end
      PLAY: begin
        if (flush) begin
          next = MUTE_TRK;
        end else if (play_done) begin
          if (can_pop) begin
            pop  = 1'b1;
            next = WR_TRK;
          end else begin
            next = MUTE_TRK;
          end
        end
      end
      MUTE_TRK: begin
        ddfs_cs      = 1'b1;
        ddfs_write   = 1'b1;
        ddfs_addr    = 5'd5;
        ddfs_wr_data = 32'(cur_voice);
        next         = MUTE_FCCW;
      end
      MUTE_FCCW: begin
        ddfs_cs    = 1'b1;
        ddfs_write = 1'b1;
        next       = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
    end else begin
      state      <= next;
      flush_pend <= flush & (state == WR_TRK);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_fccw <= '0;
      enable     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (1'b1)
        wr_stage: stage_fccw <= wr_data[PW-1:0];
        ctrl_wr:  enable     <= wr_data[0];
        default:  ;
      endcase
      if (clr_ovf)
        overflow <= 1'b0;
      else if (ovf_set)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      voice_mem[wr_ptr] <= wr_data[31:30];
      dur_mem[wr_ptr]   <= wr_data[15:0];
      fccw_mem[wr_ptr]  <= stage_fccw;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_voice <= '0;
      cur_fccw  <= '0;
      cur_dur   <= '0;
    end else if (pop) begin
      cur_voice <= voice_mem[rd_ptr];
      cur_fccw  <= fccw_mem[rd_ptr];
      cur_dur   <= dur_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      pre       <= '0;
    end else if (state == WR_FCCW) begin
      remaining <= cur_dur;
      pre       <= '0;
    end else if (state == PLAY) begin
      if (wrap) begin
        pre <= '0;
        if (remaining != 16'd0)
          remaining <= remaining - 16'd1;
      end else begin
        pre <= pre + TW'(1);
      end
    end
  end

  assign rd_data = {remaining, 6'b0, overflow,
                    cur_voice, (state != IDLE),
                    empty, full, 4'(count)};

endmodule
